sha256: RTL and testbench

Iterative SHA-256 compression core that processes one 512-bit pre-padded message block per start pulse. It computes one round per clock and chains intermediate state across the blocks of multi-block messages. It sits inside each mining processing element, which feeds it an 80-byte block header (two blocks) followed by a single-block re-hash of the 256-bit digest (double SHA-256).

---
 rtl/sha256.sv | 131 +++++++++++++
 tb/tb_sha256.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sha256.sv
// Iterative SHA-256 compression: one 512-bit block per start, one round per clock, 65-cycle start-to-done latency.
// start is ignored while busy, and a start with blk_type=11 is ignored. HEADER/MERKLE_LEAF pairs chain through hash.
module sha256 (
    input  logic         CLK,
    input  logic         nreset,
    input  logic         start,
    input  logic [511:0] msg,
    input  logic [1:0]   blk_type,
    output logic [255:0] hash,
    output logic         blk_done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    state_t       state, state_nxt;
    logic [5:0]   rnd;
    logic [31:0]  w [16];
    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [255:0] h_save;
    logic         chain;
    logic         chain_blk;

    logic         load, round_en, finish;
    logic [255:0] init_val;
    logic [31:0]  t1, t2, w_new;

    always_ff @(posedge CLK or posedge nreset) begin
        if (nreset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && blk_type != 2'b11) state_nxt = S_RUN;
            S_RUN:   if (rnd == 6'd63) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        load     = (state == S_IDLE) && start && (blk_type != 2'b11);
        round_en = (state == S_RUN);
        finish   = (state == S_FIN);
    end

    // Second block of a HEADER/MERKLE_LEAF pair continues from the digest left in hash.
    assign init_val = (blk_type != 2'b00 && chain) ? hash : IV;

    always_comb begin
        t1    = h + bsig1(e) + ((e & f) ^ (~e & g)) + K[rnd] + w[0];
        t2    = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    end

    always_ff @(posedge CLK or posedge nreset) begin
        if (nreset) begin
            for (int i = 0; i < 16; i++) w[i] <= '0;
            {a, b, c, d, e, f, g, h} <= '0;
            h_save    <= '0;
            hash      <= '0;
            blk_done  <= 1'b0;
            chain     <= 1'b0;
            chain_blk <= 1'b0;
            rnd       <= '0;
        end else begin
            blk_done <= finish;
            if (load) begin
                for (int i = 0; i < 16; i++) w[i] <= msg[511 - 32*i -: 32];
                {a, b, c, d, e, f, g, h} <= init_val;
                h_save    <= init_val;
                rnd       <= '0;
                chain_blk <= (blk_type != 2'b00);
                if (blk_type == 2'b00) chain <= 1'b0;
            end
            if (round_en) begin
                // w[0] always holds W[t]; the window slides one word per round.
                for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                w[15] <= w_new;
                h   <= g;
                g   <= f;
                f   <= e;
                e   <= d + t1;
                d   <= c;
                c   <= b;
                b   <= a;
                a   <= t1 + t2;
                rnd <= rnd + 6'd1;
            end
            if (finish) begin
                hash <= {h_save[255:224] + a, h_save[223:192] + b,
                         h_save[191:160] + c, h_save[159:128] + d,
                         h_save[127:96]  + e, h_save[95:64]   + f,
                         h_save[63:32]   + g, h_save[31:0]    + h};
                if (chain_blk) chain <= ~chain;
            end
        end
    end

endmodule

// File: tb/tb_sha256.sv
// Directed bench for sha256: known FIPS/NIST digests, latency, reset, chaining and ignored starts.
module tb_sha256;

    logic         CLK = 1'b0;
    logic         nreset = 1'b1;
    logic         start = 1'b0;
    logic [511:0] msg = '0;
    logic [1:0]   blk_type = 2'b11;
    logic [255:0] hash;
    logic         blk_done;

    int total = 0;
    int bad   = 0;
    int lat;
    int ndone;

    localparam logic [1:0] T_HASH = 2'b00, T_HEADER = 2'b10, T_IDLE = 2'b11;

    localparam logic [511:0] M_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] M_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] M_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] M_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_MID   = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_DBL   = 256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;

    localparam logic [511:0] M_DBL   = {D_EMPTY, 1'b1, 191'h0, 64'h100};

    sha256 dut (
        .CLK      (CLK),
        .nreset   (nreset),
        .start    (start),
        .msg      (msg),
        .blk_type (blk_type),
        .hash     (hash),
        .blk_done (blk_done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_blk(input logic [511:0] m, input logic [1:0] t);
        @(posedge CLK); #1;
        start = 1'b1; msg = m; blk_type = t;
        @(posedge CLK); #1;
        start = 1'b0; msg = '0; blk_type = T_IDLE;
    endtask

    // Cycles until blk_done is seen (limit+1 if never); also confirms the pulse is one cycle wide.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (n <= limit) begin
            @(posedge CLK); #1;
            n++;
            if (blk_done) break;
        end
        if (blk_done) begin
            @(posedge CLK); #1;
            check("done_one_cycle", {255'h0, blk_done}, 256'h0);
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK); #1;
            if (blk_done) cnt++;
        end
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("reset_hash", hash, 256'h0);
        check("reset_done", {255'h0, blk_done}, 256'h0);
        nreset = 1'b0;

        start_blk(M_ABC, T_HASH);
        wait_done(200, lat);
        check("abc_latency", 256'(lat), 256'd65);
        check("abc_hash", hash, D_ABC);

        // Reset while a block is in flight, asserted between edges.
        start_blk(M_EMPTY, T_HASH);
        repeat (19) begin @(posedge CLK); #1; end
        #2 nreset = 1'b1;
        #1;
        check("midreset_hash", hash, 256'h0);
        check("midreset_done", {255'h0, blk_done}, 256'h0);
        @(posedge CLK); #1;
        nreset = 1'b0;
        count_done(100, ndone);
        check("midreset_no_done", 256'(ndone), 256'd0);

        start_blk(M_ABC, T_HASH);
        wait_done(200, lat);
        check("abc2_latency", 256'(lat), 256'd65);
        check("abc2_hash", hash, D_ABC);

        start_blk(M_EMPTY, T_HASH);
        wait_done(200, lat);
        check("empty_hash", hash, D_EMPTY);

        start_blk(M_TWO1, T_HEADER);
        wait_done(200, lat);
        check("hdr_blk1_hash", hash, D_MID);
        start_blk(M_TWO2, T_HEADER);
        wait_done(200, lat);
        check("hdr_blk2_latency", 256'(lat), 256'd65);
        check("hdr_blk2_hash", hash, D_TWO);

        start_blk(M_DBL, T_HASH);
        wait_done(200, lat);
        check("double_hash", hash, D_DBL);

        start_blk(M_TWO1, T_HEADER);
        wait_done(200, lat);
        check("hdr_restart_iv", hash, D_MID);
        start_blk(M_TWO2, T_HEADER);
        wait_done(200, lat);
        check("hdr_rechain", hash, D_TWO);

        // Back-to-back: start presented on the cycle right after blk_done.
        @(posedge CLK); #1;
        start = 1'b1; msg = M_ABC; blk_type = T_HASH;
        lat = 0;
        while (lat < 200 && !blk_done) begin @(posedge CLK); #1; lat++; end
        check("b2b_first_hash", hash, D_ABC);
        msg = M_EMPTY;
        @(posedge CLK); #1;
        start = 1'b0; msg = '0; blk_type = T_IDLE;
        wait_done(200, lat);
        check("b2b_second_latency", 256'(lat), 256'd65);
        check("b2b_second_hash", hash, D_EMPTY);

        // A start arriving mid-block is dropped.
        start_blk(M_ABC, T_HASH);
        repeat (9) begin @(posedge CLK); #1; end
        start = 1'b1; msg = M_TWO1; blk_type = T_HEADER;
        @(posedge CLK); #1;
        start = 1'b0; msg = '0; blk_type = T_IDLE;
        wait_done(200, lat);
        check("busy_start_latency", 256'(lat), 256'd55);
        check("busy_start_hash", hash, D_ABC);
        count_done(100, ndone);
        check("busy_start_no_extra", 256'(ndone), 256'd0);

        start_blk(M_EMPTY, T_IDLE);
        count_done(100, ndone);
        check("idle_type_no_done", 256'(ndone), 256'd0);
        check("idle_type_hash_held", hash, D_ABC);

        // The dropped HEADER start must not have disturbed the chain flag.
        start_blk(M_TWO1, T_HEADER);
        wait_done(200, lat);
        check("post_ignore_hdr1", hash, D_MID);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
